// File: rtl/step_delay_timer.sv
// -----------------------------------------------------------------------------
// step_delay_timer
//
// Delay timer for the stepper sequencer. A start command loads a delay in
// units of BASIC_PERIOD clocks; the timer counts it down and pulses `expire`
// when it runs out. One-shot mode stops and raises the sticky `done` flag.
// Auto-reload mode reloads the latched delay and keeps running.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      load delay/periodic and (re)start counting
//   stop       abort the current count (wins over start)
//   enable     count enable; low freezes prescaler and remaining
//   periodic   0 = one-shot, 1 = auto-reload (sampled with start)
//   delay      delay in units (sampled with start)
//   busy       high while in RUN
//   done       sticky one-shot completion flag, cleared by start
//   expire     one-cycle pulse at each expiry
//   tick       one-cycle pulse at each unit boundary
//   remaining  units left in the current period
// -----------------------------------------------------------------------------
module step_delay_timer #(
  parameter int PERIOD_W     = 20,
  parameter int BASIC_PERIOD = 500000,
  parameter int DELAY_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               enable,
  input  logic               periodic,
  input  logic [DELAY_W-1:0] delay,
  output logic               busy,
  output logic               done,
  output logic               expire,
  output logic               tick,
  output logic [DELAY_W-1:0] remaining
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PERIOD_W-1:0] PRESCALE_LAST = PERIOD_W'(BASIC_PERIOD - 1);
  localparam logic [DELAY_W-1:0]  ONE_UNIT      = DELAY_W'(1);

  state_t              state;
  logic [PERIOD_W-1:0] prescaler;
  logic [DELAY_W-1:0]  delay_q;
  logic                periodic_q;

  // busy is a direct decode of the state register, so it is registered too.
  assign busy = (state == RUN);

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments, so every read below sees the value from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      prescaler  <= '0;
      remaining  <= '0;
      delay_q    <= '0;
      periodic_q <= 1'b0;
      done       <= 1'b0;
      expire     <= 1'b0;
      tick       <= 1'b0;
    end else begin
      // Pulses default low; they are raised only on the edge that earns them.
      expire <= 1'b0;
      tick   <= 1'b0;

      if (stop) begin
        // Abort: remaining and done are deliberately left as they were.
        state     <= IDLE;
        prescaler <= '0;
      end else if (start) begin
        prescaler <= '0;
        delay_q   <= delay;
        if (delay != '0) begin
          periodic_q <= periodic;
          remaining  <= delay;
          done       <= 1'b0;
          state      <= RUN;
        end else begin
          // Zero delay expires immediately, always as a one-shot.
          periodic_q <= 1'b0;
          remaining  <= '0;
          done       <= 1'b1;
          expire     <= 1'b1;
          state      <= IDLE;
        end
      end else if (state == RUN && enable) begin
        if (prescaler == PRESCALE_LAST) begin
          prescaler <= '0;
          tick      <= 1'b1;
          if (remaining == ONE_UNIT) begin
            expire <= 1'b1;
            if (periodic_q) begin
              remaining <= delay_q;
            end else begin
              remaining <= '0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            remaining <= remaining - ONE_UNIT;
          end
        end else begin
          prescaler <= prescaler + PERIOD_W'(1);
        end
      end
    end
  end

endmodule
